drive_sequencer: RTL and testbench

Mission-level sequencer that sits directly upstream of the two `stepctl` motor controllers and drives their go pulse, step target, direction and stop inputs. A start pulse launches a forward run. A debounced bump on either side aborts the run and triggers a recovery: halt, back up, turn away from the obstacle, then relaunch. It reports completion, or a fault after too many recoveries.

---
 rtl/drive_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_drive_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Mission sequencer upstream of the two stepctl motor controllers: forward run with
// bump-triggered halt / back-up / turn-away recovery, completion and retry-fault reporting.
module drive_sequencer #(
  parameter logic [15:0] FWD_STEPS  = 16'd18000,
  parameter logic [15:0] BACK_STEPS = 16'd360,
  parameter logic [15:0] TURN_STEPS = 16'd180,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DEB_CYCLES = 12000,
  parameter int unsigned SETTLE     = 4
) (
  input  logic        WF_CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  bump,
  input  logic        motorL_busy,
  input  logic        motorR_busy,
  output logic        go,
  output logic [15:0] motorL_steps,
  output logic [15:0] motorR_steps,
  output logic        motorL_dir,
  output logic        motorR_dir,
  output logic        motorL_stop,
  output logic        motorR_stop,
  output logic        done,
  output logic        fault,
  output logic [2:0]  state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FWD   = 3'd1;
  localparam logic [2:0] HALT  = 3'd2;
  localparam logic [2:0] BACK  = 3'd3;
  localparam logic [2:0] TURN  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] FAULT = 3'd6;

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SetW = $clog2(SETTLE + 1);
  localparam int unsigned RetW = $clog2(MAX_RETRY + 1);

  logic [5:0]      sync1_q, sync2_q, deb_q;
  logic [DebW-1:0] deb_cnt_q [6];

  // Bump switches are active-low; a bit only flips after DEB_CYCLES disagreeing samples.
  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
      deb_q   <= 6'h3F;
      for (int i = 0; i < 6; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= bump;
      sync2_q <= sync1_q;
      for (int i = 0; i < 6; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic hit_r, hit_l;
  assign hit_r = ~&deb_q[2:0];
  assign hit_l = ~&deb_q[5:3];

  logic [2:0]      state_q, state_d;
  logic            go_q, go_d;
  logic [15:0]     steps_l_q, steps_l_d, steps_r_q, steps_r_d;
  logic            dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic [RetW-1:0] retry_q, retry_d;
  logic            side_r_q, side_r_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic            leg_over;

  assign leg_over = (settle_q == SetW'(SETTLE)) && !motorL_busy && !motorR_busy;

  always_comb begin
    state_d   = state_q;
    go_d      = 1'b0;
    steps_l_d = steps_l_q;
    steps_r_d = steps_r_q;
    dir_l_d   = dir_l_q;
    dir_r_d   = dir_r_q;
    retry_d   = retry_q;
    side_r_d  = side_r_q;
    settle_d  = (settle_q == SetW'(SETTLE)) ? settle_q : settle_q + 1'b1;
    case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d   = FWD;
          go_d      = 1'b1;
          steps_l_d = FWD_STEPS;
          steps_r_d = FWD_STEPS;
          dir_l_d   = 1'b0;
          dir_r_d   = 1'b0;
          retry_d   = '0;
        end
      end
      FWD: begin
        // A bump outranks a completion seen on the same cycle.
        if (hit_r || hit_l) begin
          if (retry_q == RetW'(MAX_RETRY)) begin
            state_d = FAULT;
          end else begin
            state_d  = HALT;
            retry_d  = retry_q + 1'b1;
            side_r_d = hit_r;
          end
        end else if (leg_over) begin
          state_d = DONE;
        end
      end
      HALT: begin
        if (leg_over) begin
          state_d   = BACK;
          go_d      = 1'b1;
          steps_l_d = BACK_STEPS;
          steps_r_d = BACK_STEPS;
          dir_l_d   = 1'b1;
          dir_r_d   = 1'b1;
        end
      end
      BACK: begin
        if (leg_over) begin
          state_d   = TURN;
          go_d      = 1'b1;
          steps_l_d = TURN_STEPS;
          steps_r_d = TURN_STEPS;
          dir_l_d   = side_r_q;
          dir_r_d   = ~side_r_q;
        end
      end
      TURN: begin
        if (leg_over) begin
          state_d   = FWD;
          go_d      = 1'b1;
          steps_l_d = FWD_STEPS;
          steps_r_d = FWD_STEPS;
          dir_l_d   = 1'b0;
          dir_r_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) settle_d = '0;
  end

  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      steps_l_q <= '0;
      steps_r_q <= '0;
      dir_l_q   <= 1'b0;
      dir_r_q   <= 1'b0;
      retry_q   <= '0;
      side_r_q  <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      steps_l_q <= steps_l_d;
      steps_r_q <= steps_r_d;
      dir_l_q   <= dir_l_d;
      dir_r_q   <= dir_r_d;
      retry_q   <= retry_d;
      side_r_q  <= side_r_d;
      settle_q  <= settle_d;
    end
  end

  logic moving;
  assign moving = (state_q == FWD) || (state_q == BACK) || (state_q == TURN);

  assign go           = go_q;
  assign motorL_steps = steps_l_q;
  assign motorR_steps = steps_r_q;
  assign motorL_dir   = dir_l_q;
  assign motorR_dir   = dir_r_q;
  assign motorL_stop  = ~moving;
  assign motorR_stop  = ~moving;
  assign done         = (state_q == DONE);
  assign fault        = (state_q == FAULT);
  assign state        = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a simple busy model (20 cycles after go, cleared by stop).
module tb_drive_sequencer;

  logic        WF_CLK = 1'b0;
  logic        rst, start;
  logic [5:0]  bump;
  logic        busy;
  logic        go, motorL_dir, motorR_dir, motorL_stop, motorR_stop, done, fault;
  logic [15:0] motorL_steps, motorR_steps;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int go_total = 0;
  int halt_total = 0;
  logic [2:0] prev_state = 3'd0;

  always #5 WF_CLK = ~WF_CLK;

  drive_sequencer #(
    .FWD_STEPS (16'd100),
    .BACK_STEPS(16'd10),
    .TURN_STEPS(16'd5),
    .MAX_RETRY (3),
    .DEB_CYCLES(4),
    .SETTLE    (4)
  ) dut (
    .WF_CLK      (WF_CLK),
    .rst         (rst),
    .start       (start),
    .bump        (bump),
    .motorL_busy (busy),
    .motorR_busy (busy),
    .go          (go),
    .motorL_steps(motorL_steps),
    .motorR_steps(motorR_steps),
    .motorL_dir  (motorL_dir),
    .motorR_dir  (motorR_dir),
    .motorL_stop (motorL_stop),
    .motorR_stop (motorR_stop),
    .done        (done),
    .fault       (fault),
    .state       (state)
  );

  always @(posedge WF_CLK) begin
    if (go) busy_cnt <= 20;
    else if (motorL_stop) busy_cnt <= 0;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (go) go_total <= go_total + 1;
    if (state == 3'd2 && prev_state != 3'd2) halt_total <= halt_total + 1;
    prev_state <= state;
  end
  assign busy = (busy_cnt != 0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge WF_CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int max,
                            output int n);
    n = 0;
    while (state !== target && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(state), 32'(target));
  endtask

  int n, h0, g0;

  initial begin
    rst = 1'b1; start = 1'b0; bump = 6'h3F;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_go", 32'(go), 0);
    check_eq("rst_stops", 32'({motorL_stop, motorR_stop}), 3);
    check_eq("rst_steps", 32'({motorL_steps, motorR_steps}), 0);
    check_eq("rst_dirs", 32'({motorL_dir, motorR_dir}), 0);
    check_eq("rst_done_fault", 32'({done, fault}), 0);

    // Clean run
    g0 = go_total;
    pulse_start();
    check_eq("clean_state", 32'(state), 1);
    check_eq("clean_go", 32'(go), 1);
    check_eq("clean_steps", 32'({motorL_steps, motorR_steps}), {16'd100, 16'd100});
    check_eq("clean_dirs", 32'({motorL_dir, motorR_dir}), 0);
    check_eq("clean_stops", 32'({motorL_stop, motorR_stop}), 0);
    tick(); tick(); tick();
    pulse_start();
    check_eq("clean_start_ignored", 32'({state, go}), {3'd1, 1'b0});
    wait_state("clean_done_state", 3'd5, 100, n);
    check_eq("clean_done_time", n, 18);
    check_eq("clean_done_flag", 32'({done, fault}), 2);
    check_eq("clean_done_stops", 32'({motorL_stop, motorR_stop}), 3);
    check_eq("clean_go_count", go_total - g0, 1);

    // Right bump
    pulse_start();
    tick();
    bump[1] = 1'b0;
    repeat (6) tick();
    check_eq("rbump_pre_halt", 32'(state), 1);
    tick();
    check_eq("rbump_halt", 32'(state), 2);
    check_eq("rbump_halt_stops", 32'({motorL_stop, motorR_stop}), 3);
    bump = 6'h3F;
    wait_state("rbump_back_state", 3'd3, 50, n);
    check_eq("rbump_back_time", n, 5);
    check_eq("rbump_back_go", 32'(go), 1);
    check_eq("rbump_back_steps", 32'({motorL_steps, motorR_steps}), {16'd10, 16'd10});
    check_eq("rbump_back_dirs", 32'({motorL_dir, motorR_dir}), 3);
    wait_state("rbump_turn_state", 3'd4, 50, n);
    check_eq("rbump_turn_time", n, 22);
    check_eq("rbump_turn_go", 32'(go), 1);
    check_eq("rbump_turn_steps", 32'({motorL_steps, motorR_steps}), {16'd5, 16'd5});
    check_eq("rbump_turn_dirs", 32'({motorL_dir, motorR_dir}), 2);
    wait_state("rbump_fwd_state", 3'd1, 50, n);
    check_eq("rbump_fwd_go", 32'(go), 1);
    check_eq("rbump_fwd_steps", 32'({motorL_steps, motorR_steps}), {16'd100, 16'd100});
    check_eq("rbump_fwd_dirs", 32'({motorL_dir, motorR_dir}), 0);
    wait_state("rbump_done", 3'd5, 50, n);

    // Both sides pressed together count as a right-side hit
    pulse_start();
    tick();
    bump = 6'b101110;
    wait_state("both_halt", 3'd2, 20, n);
    bump = 6'h3F;
    wait_state("both_turn_state", 3'd4, 60, n);
    check_eq("both_turn_dirs", 32'({motorL_dir, motorR_dir}), 2);
    wait_state("both_done", 3'd5, 100, n);

    // Glitch shorter than the debounce window
    h0 = halt_total;
    pulse_start();
    tick();
    bump[3] = 1'b0;
    repeat (3) tick();
    bump = 6'h3F;
    wait_state("glitch_done_state", 3'd5, 100, n);
    check_eq("glitch_done_time", n, 18);
    check_eq("glitch_no_halt", halt_total - h0, 0);

    // Retry exhaustion
    h0 = halt_total;
    pulse_start();
    tick();
    bump[5] = 1'b0;
    wait_state("retry_fault_state", 3'd6, 600, n);
    check_eq("retry_halt_count", halt_total - h0, 3);
    check_eq("retry_flags", 32'({done, fault}), 1);
    check_eq("retry_stops", 32'({motorL_stop, motorR_stop}), 3);
    bump = 6'h3F;
    repeat (10) tick();
    pulse_start();
    check_eq("retry_restart", 32'({state, go, fault}), {3'd1, 1'b1, 1'b0});

    // Reset mid-BACK, then confirm the full retry budget is available again
    bump[2] = 1'b0;
    wait_state("rmid_halt", 3'd2, 20, n);
    bump = 6'h3F;
    wait_state("rmid_back", 3'd3, 20, n);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rmid_state", 32'(state), 0);
    check_eq("rmid_stops", 32'({motorL_stop, motorR_stop}), 3);
    check_eq("rmid_go", 32'(go), 0);
    check_eq("rmid_steps", 32'({motorL_steps, motorR_steps}), 0);
    h0 = halt_total;
    pulse_start();
    bump[5] = 1'b0;
    wait_state("rmid_fault_state", 3'd6, 600, n);
    check_eq("rmid_retry_cleared", halt_total - h0, 3);
    bump = 6'h3F;
    repeat (10) tick();

    // Reset beats a simultaneous start
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_state", 32'({state, go}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
